tt_trace_capture: RTL

Parametrised logic-analyser-style trace buffer for the debugger microcode top level. It samples a probe bus every enabled cycle into a circular buffer and watches for a masked-match trigger. After the trigger it captures a programmable number of post-trigger samples, then freezes. The frozen trace reads out oldest-first through a one-sample-per-request port, which the top level multiplexes onto `uo_out`.

---
 rtl/tt_trace_capture_if.sv | 12 +
 rtl/tt_trace_capture.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tt_trace_capture_if.sv
// Readout port of the trace buffer: one-sample-per-request pull interface.
// The requester (master) drives rd_en; the buffer (slave) answers a cycle later.
interface tt_trace_capture_if #(
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (output rd_en, input rd_data, input rd_valid);
    modport slave  (input rd_en, output rd_data, output rd_valid);
endinterface

// File: rtl/tt_trace_capture.sv
// Logic-analyser trace buffer: circular pre-trigger capture, masked trigger,
// programmable post-trigger count, then frozen oldest-first readout.
module tt_trace_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [DATA_W-1:0]      probe,
    input  logic [DATA_W-1:0]      trig_mask,
    input  logic [DATA_W-1:0]      trig_value,
    input  logic [ADDR_W-1:0]      post_count,
    input  logic                   arm,
    tt_trace_capture_if.slave      rd,
    output logic [1:0]             state,
    output logic [ADDR_W:0]        fill
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [ADDR_W:0]   rcnt_q, rcnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              trig_hit;
    logic [ADDR_W-1:0] wptr_inc;
    logic [ADDR_W:0]   fill_inc;
    logic [ADDR_W-1:0] done_rptr;

    assign trig_hit = (probe & trig_mask) == (trig_value & trig_mask);
    assign wptr_inc = wptr_q + 1'b1;
    assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    // Oldest sample sits at the next write slot once the buffer has wrapped.
    assign done_rptr = (fill_inc == FULL) ? wptr_inc : '0;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        post_d     = post_q;
        fill_d     = fill_q;
        rcnt_d     = rcnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;

        if (ena) begin
            if (arm) begin
                state_d = ST_ARMED;
                wptr_d  = '0;
                rptr_d  = '0;
                fill_d  = '0;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_inc;
                        fill_d = fill_inc;
                        if (trig_hit) begin
                            if (post_count == '0) begin
                                state_d = ST_DONE;
                                rptr_d  = done_rptr;
                                rcnt_d  = '0;
                            end else begin
                                state_d = ST_POST;
                                post_d  = post_count;
                            end
                        end
                    end
                    ST_POST: begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_inc;
                        fill_d = fill_inc;
                        post_d = post_q - 1'b1;
                        if (post_q == ADDR_W'(1)) begin
                            state_d = ST_DONE;
                            rptr_d  = done_rptr;
                            rcnt_d  = '0;
                        end
                    end
                    ST_DONE: begin
                        if (rd.rd_en && (rcnt_q < fill_q)) begin
                            rd_data_d  = mem[rptr_q];
                            rd_valid_d = 1'b1;
                            rptr_d     = rptr_q + 1'b1;
                            rcnt_d     = rcnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            post_q     <= '0;
            fill_q     <= '0;
            rcnt_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            post_q     <= post_d;
            fill_q     <= fill_d;
            rcnt_q     <= rcnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sample storage carries no reset; validity is tracked by fill.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wptr_q] <= probe;
        end
    end

    assign state       = state_q;
    assign fill        = fill_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_valid = rd_valid_q;
endmodule
